// File: rtl/cla_pipe_adder.sv
// cla_pipe_adder
//
// Pipelined carry-lookahead adder/subtractor. The operands are cut into
// GROUP-bit lookahead groups and each group is resolved in its own pipeline
// stage, so the critical path is one group-wide lookahead no matter how wide
// WIDTH gets. The carry out of each group is registered and handed to the
// next stage together with the still-unconsumed upper operand slices (skew
// registers) and the sum bits resolved so far.
//
// Parameters
//   WIDTH   operand/sum width, a multiple of GROUP (minimum 2)
//   GROUP   bits per lookahead group (2 or 4)
//   STAGES  derived, WIDTH/GROUP; pipeline depth and latency
//
// Ports
//   clk        clock, all state changes on the rising edge
//   reset      synchronous, active-high; empties the pipeline
//   in_valid   operand beat present
//   in_ready   block accepts a beat this cycle
//   a, b       operands
//   cin        carry-in for add, ignored for subtract
//   sub        0: a+b+cin   1: a-b (a + ~b + 1)
//   out_valid  result beat present
//   out_ready  downstream takes the result
//   sum        result bits
//   cout       carry out of the MSB (for subtract, 1 = no borrow)
//   ovf        two's-complement overflow
//
// Handshake: a transfer happens on a rising edge where valid and ready are
// both 1. A producer holding valid=1 keeps its payload stable until the
// transfer. The whole pipeline shares one enable, en = !out_valid | out_ready,
// so a stalled output freezes every stage (bubbles included) and in_ready
// simply mirrors en. Results leave in acceptance order, none are dropped.

module cla_pipe_adder #(
    parameter int WIDTH = 16,
    parameter int GROUP = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / GROUP;

    // Global pipeline enable: advance unless a result is stuck at the output.
    logic en;
    assign en       = ~out_valid | out_ready;
    assign in_ready = en;

    // Carry into every bit of a group, each written as a flat sum of
    // products of the group-local p/g and the incoming carry (no ripple).
    function automatic logic [GROUP-1:0] bit_carries(
        input logic [GROUP-1:0] p,
        input logic [GROUP-1:0] g,
        input logic             c0
    );
        logic [GROUP-1:0] c;
        logic             term;
        c = '0;
        for (int i = 0; i < GROUP; i++) begin
            term = c0;
            for (int j = 0; j < i; j++) begin
                term = term & p[j];
            end
            c[i] = term;
            for (int j = 0; j < i; j++) begin
                term = g[j];
                for (int m = j + 1; m < i; m++) begin
                    term = term & p[m];
                end
                c[i] = c[i] | term;
            end
        end
        return c;
    endfunction

    // Group generate: the group produces a carry out regardless of carry in.
    function automatic logic group_generate(
        input logic [GROUP-1:0] p,
        input logic [GROUP-1:0] g
    );
        logic gg;
        logic term;
        gg = 1'b0;
        for (int j = 0; j < GROUP; j++) begin
            term = g[j];
            for (int m = j + 1; m < GROUP; m++) begin
                term = term & p[m];
            end
            gg = gg | term;
        end
        return gg;
    endfunction

    genvar k;
    generate
        for (k = 0; k < STAGES; k++) begin : stg
            // Operand bits still to be consumed on entry to this stage, and
            // sum bits known after this stage.
            localparam int IN_W  = WIDTH - k * GROUP;
            localparam int SUM_W = (k + 1) * GROUP;

            logic [IN_W-1:0]  a_in;
            logic [IN_W-1:0]  b_in;
            logic             c_in;
            logic             v_in;
            logic [GROUP-1:0] p;
            logic [GROUP-1:0] g;
            logic [GROUP-1:0] c_bit;
            logic [GROUP-1:0] s_grp;
            logic             grp_p;
            logic             grp_g;
            logic             c_out;
            logic [SUM_W-1:0] s_nxt;

            logic             v_q;
            logic             c_q;
            logic [SUM_W-1:0] s_q;

            if (k == 0) begin : head
                // Subtract is a + ~b + 1: invert b and force the carry in.
                assign a_in  = a;
                assign b_in  = b ^ {WIDTH{sub}};
                assign c_in  = sub | cin;
                assign v_in  = in_valid;
                assign s_nxt = s_grp;
            end else begin : link
                assign a_in  = stg[k-1].skew.a_q;
                assign b_in  = stg[k-1].skew.b_q;
                assign c_in  = stg[k-1].c_q;
                assign v_in  = stg[k-1].v_q;
                assign s_nxt = {s_grp, stg[k-1].s_q};
            end

            // The group being resolved here always sits in the low bits of
            // the operand view because the skew registers drop consumed bits.
            assign p     = a_in[GROUP-1:0] ^ b_in[GROUP-1:0];
            assign g     = a_in[GROUP-1:0] & b_in[GROUP-1:0];
            assign c_bit = bit_carries(p, g, c_in);
            assign grp_p = &p;
            assign grp_g = group_generate(p, g);
            assign c_out = grp_g | (grp_p & c_in);
            assign s_grp = p ^ c_bit;

            // Payload only loads with a valid beat, so the last stage (the
            // output register) keeps its old result across bubbles.
            always_ff @(posedge clk) begin
                if (reset) begin
                    v_q <= 1'b0;
                    c_q <= 1'b0;
                    s_q <= '0;
                end else if (en) begin
                    v_q <= v_in;
                    if (v_in) begin
                        c_q <= c_out;
                        s_q <= s_nxt;
                    end
                end
            end

            if (k < STAGES - 1) begin : skew
                logic [IN_W-GROUP-1:0] a_q;
                logic [IN_W-GROUP-1:0] b_q;

                always_ff @(posedge clk) begin
                    if (reset) begin
                        a_q <= '0;
                        b_q <= '0;
                    end else if (en && v_in) begin
                        a_q <= a_in[IN_W-1:GROUP];
                        b_q <= b_in[IN_W-1:GROUP];
                    end
                end
            end

            if (k == STAGES - 1) begin : tail
                // This stage owns the MSB: overflow is carry-into-MSB xor
                // carry-out-of-MSB, registered alongside the sum.
                logic ovf_q;

                always_ff @(posedge clk) begin
                    if (reset) begin
                        ovf_q <= 1'b0;
                    end else if (en && v_in) begin
                        ovf_q <= c_bit[GROUP-1] ^ c_out;
                    end
                end
            end
        end
    endgenerate

    assign out_valid = stg[STAGES-1].v_q;
    assign sum       = stg[STAGES-1].s_q;
    assign cout      = stg[STAGES-1].c_q;
    assign ovf       = stg[STAGES-1].tail.ovf_q;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Bench for cla_pipe_adder: five instances cover STAGES=1 (4/4), a 4-stage
// 2-bit-group chain (8/2), 8/4, the default 16/4, and a 12/2 random run.

module tb_cla_pipe_adder;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic reset;   // shared by all instances except d16
    logic rst16;   // d16 has its own reset for the mid-stream reset test
    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0h, expected %0h", tag, got, exp);
        end
    endtask

    // ---------------- DUT signals ----------------
    logic d44_in_valid, d44_in_ready, d44_cin, d44_sub, d44_out_valid, d44_out_ready, d44_cout, d44_ovf;
    logic [3:0] d44_a, d44_b, d44_sum;
    logic d82_in_valid, d82_in_ready, d82_cin, d82_sub, d82_out_valid, d82_out_ready, d82_cout, d82_ovf;
    logic [7:0] d82_a, d82_b, d82_sum;
    logic d84_in_valid, d84_in_ready, d84_cin, d84_sub, d84_out_valid, d84_out_ready, d84_cout, d84_ovf;
    logic [7:0] d84_a, d84_b, d84_sum;
    logic d16_in_valid, d16_in_ready, d16_cin, d16_sub, d16_out_valid, d16_out_ready, d16_cout, d16_ovf;
    logic [15:0] d16_a, d16_b, d16_sum;
    logic d12_in_valid, d12_in_ready, d12_cin, d12_sub, d12_out_valid, d12_out_ready, d12_cout, d12_ovf;
    logic [11:0] d12_a, d12_b, d12_sum;

    cla_pipe_adder #(.WIDTH(4), .GROUP(4)) u_d44 (
        .clk(clk), .reset(reset), .in_valid(d44_in_valid), .in_ready(d44_in_ready),
        .a(d44_a), .b(d44_b), .cin(d44_cin), .sub(d44_sub),
        .out_valid(d44_out_valid), .out_ready(d44_out_ready),
        .sum(d44_sum), .cout(d44_cout), .ovf(d44_ovf));

    cla_pipe_adder #(.WIDTH(8), .GROUP(2)) u_d82 (
        .clk(clk), .reset(reset), .in_valid(d82_in_valid), .in_ready(d82_in_ready),
        .a(d82_a), .b(d82_b), .cin(d82_cin), .sub(d82_sub),
        .out_valid(d82_out_valid), .out_ready(d82_out_ready),
        .sum(d82_sum), .cout(d82_cout), .ovf(d82_ovf));

    cla_pipe_adder #(.WIDTH(8), .GROUP(4)) u_d84 (
        .clk(clk), .reset(reset), .in_valid(d84_in_valid), .in_ready(d84_in_ready),
        .a(d84_a), .b(d84_b), .cin(d84_cin), .sub(d84_sub),
        .out_valid(d84_out_valid), .out_ready(d84_out_ready),
        .sum(d84_sum), .cout(d84_cout), .ovf(d84_ovf));

    cla_pipe_adder #(.WIDTH(16), .GROUP(4)) u_d16 (
        .clk(clk), .reset(rst16), .in_valid(d16_in_valid), .in_ready(d16_in_ready),
        .a(d16_a), .b(d16_b), .cin(d16_cin), .sub(d16_sub),
        .out_valid(d16_out_valid), .out_ready(d16_out_ready),
        .sum(d16_sum), .cout(d16_cout), .ovf(d16_ovf));

    cla_pipe_adder #(.WIDTH(12), .GROUP(2)) u_d12 (
        .clk(clk), .reset(reset), .in_valid(d12_in_valid), .in_ready(d12_in_ready),
        .a(d12_a), .b(d12_b), .cin(d12_cin), .sub(d12_sub),
        .out_valid(d12_out_valid), .out_ready(d12_out_ready),
        .sum(d12_sum), .cout(d12_cout), .ovf(d12_ovf));

    // ---------------- reference model ----------------
    // Signed/unsigned integer arithmetic; result packed as {cout, ovf, sum}.
    function automatic logic [17:0] model(input int w, input logic [15:0] va, input logic [15:0] vb,
                                          input logic vcin, input logic vsub);
        int sa, sb, r, ua, ub;
        logic c, o;
        ua = int'(va);
        ub = int'(vb);
        sa = va[w-1] ? ua - (1 << w) : ua;
        sb = vb[w-1] ? ub - (1 << w) : ub;
        if (vsub) begin
            r = sa - sb;
            c = (ua >= ub);
        end else begin
            r = sa + sb + int'(vcin);
            c = ((ua + ub + int'(vcin)) >= (1 << w));
        end
        o = (r > (1 << (w - 1)) - 1) || (r < -(1 << (w - 1)));
        return {c, o, 16'(r & ((1 << w) - 1))};
    endfunction

    // ---------------- scoreboards ----------------
    logic [17:0] exp16_q[$];
    logic [17:0] exp12_q[$];
    logic [17:0] mon16_exp, mon12_exp;
    int first16 = -1, last16 = -1, got16 = 0, acc_cyc16 = 0;

    always @(negedge clk) begin
        if (!rst16 && d16_out_valid && d16_out_ready) begin
            check("d16_has_exp", 32'(exp16_q.size() != 0), 1);
            if (exp16_q.size() != 0) begin
                mon16_exp = exp16_q.pop_front();
                check("d16_result", {14'd0, d16_cout, d16_ovf, d16_sum}, {14'd0, mon16_exp});
                if (first16 < 0) first16 = cyc;
                last16 = cyc;
                got16++;
            end
        end
    end

    always @(negedge clk) begin
        if (!reset && d12_out_valid && d12_out_ready) begin
            check("d12_has_exp", 32'(exp12_q.size() != 0), 1);
            if (exp12_q.size() != 0) begin
                mon12_exp = exp12_q.pop_front();
                check("d12_result", {14'd0, d12_cout, d12_ovf, 4'd0, d12_sum}, {14'd0, mon12_exp});
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic send16(input logic [15:0] va, input logic [15:0] vb, input logic vcin,
                          input logic vsub, input logic [17:0] ex);
        logic acc;
        acc = 1'b0;
        d16_a = va; d16_b = vb; d16_cin = vcin; d16_sub = vsub; d16_in_valid = 1'b1;
        for (int t = 0; t < 50 && !acc; t++) begin
            @(negedge clk);
            if (d16_in_ready) begin
                acc = 1'b1;
                acc_cyc16 = cyc;
                exp16_q.push_back(ex);
            end
            @(posedge clk); #1;
        end
        d16_in_valid = 1'b0;
        check("d16_accept", 32'(acc), 1);
    endtask

    task automatic send12(input logic [11:0] va, input logic [11:0] vb, input logic vcin, input logic vsub);
        logic acc;
        acc = 1'b0;
        d12_a = va; d12_b = vb; d12_cin = vcin; d12_sub = vsub; d12_in_valid = 1'b1;
        for (int t = 0; t < 200 && !acc; t++) begin
            @(negedge clk);
            if (d12_in_ready) begin
                acc = 1'b1;
                exp12_q.push_back(model(12, {4'd0, va}, {4'd0, vb}, vcin, vsub));
            end
            @(posedge clk); #1;
        end
        d12_in_valid = 1'b0;
        check("d12_accept", 32'(acc), 1);
    endtask

    task automatic drain16();
        for (int t = 0; t < 100 && exp16_q.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        check("d16_drain", exp16_q.size(), 0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- main sequence ----------------
    logic [7:0]  t82_a[4], t82_b[4];
    logic        t82_cin[4], t82_sub[4];
    logic [9:0]  t82_exp[4];
    logic [17:0] held;
    logic        rand_done;
    int          lat;

    initial begin
        reset = 1'b1; rst16 = 1'b1; rand_done = 1'b0;
        {d44_in_valid, d44_cin, d44_sub, d44_a, d44_b} = '0; d44_out_ready = 1'b1;
        {d82_in_valid, d82_cin, d82_sub, d82_a, d82_b} = '0; d82_out_ready = 1'b1;
        {d84_in_valid, d84_cin, d84_sub, d84_a, d84_b} = '0; d84_out_ready = 1'b1;
        {d16_in_valid, d16_cin, d16_sub, d16_a, d16_b} = '0; d16_out_ready = 1'b1;
        {d12_in_valid, d12_cin, d12_sub, d12_a, d12_b} = '0; d12_out_ready = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("rst_in_ready", d16_in_ready, 1);
        check("rst_out_valid", d16_out_valid, 0);
        check("rst_sum", d16_sum, 0);
        check("rst_cout", d16_cout, 0);
        check("rst_ovf", d16_ovf, 0);
        check("rst_d12_out_valid", d12_out_valid, 0);
        reset = 1'b0; rst16 = 1'b0;
        @(posedge clk); #1;

        // STAGES=1: a single registered CLA, latency 1.
        d44_a = 4'hF; d44_b = 4'h1; d44_in_valid = 1'b1;
        @(posedge clk); #1;
        d44_a = 4'h7; d44_b = 4'h1;
        check("d44_valid0", d44_out_valid, 1);
        check("d44_res0", {d44_cout, d44_ovf, d44_sum}, {1'b1, 1'b0, 4'h0});
        @(posedge clk); #1;
        d44_in_valid = 1'b0;
        check("d44_res1", {d44_cout, d44_ovf, d44_sum}, {1'b0, 1'b1, 4'h8});
        @(posedge clk); #1;
        check("d44_bubble_valid", d44_out_valid, 0);
        check("d44_bubble_hold", {d44_cout, d44_ovf, d44_sum}, {1'b0, 1'b1, 4'h8});

        // 8/2: four stages, full-chain carry and latency.
        t82_a   = '{8'hFF, 8'h7F, 8'h80, 8'h00};
        t82_b   = '{8'h00, 8'h01, 8'h80, 8'h01};
        t82_cin = '{1'b1, 1'b0, 1'b0, 1'b0};
        t82_sub = '{1'b0, 1'b0, 1'b0, 1'b1};
        t82_exp = '{{1'b1, 1'b0, 8'h00}, {1'b0, 1'b1, 8'h80}, {1'b1, 1'b1, 8'h00}, {1'b0, 1'b0, 8'hFF}};
        for (int i = 0; i < 4; i++) begin
            d82_a = t82_a[i]; d82_b = t82_b[i]; d82_cin = t82_cin[i]; d82_sub = t82_sub[i];
            d82_in_valid = 1'b1;
            @(negedge clk);
            check("d82_in_ready", d82_in_ready, 1);
            @(posedge clk); #1;
            d82_in_valid = 1'b0;
            lat = 1;
            while (!d82_out_valid && lat < 20) begin
                @(posedge clk); #1;
                lat++;
            end
            check("d82_latency", lat, 4);
            check("d82_result", {d82_cout, d82_ovf, d82_sum}, t82_exp[i]);
            @(posedge clk); #1;
        end

        // 8/4 subtract, back-to-back; cin is ignored when sub=1.
        d84_a = 8'h80; d84_b = 8'h01; d84_sub = 1'b1; d84_cin = 1'b0; d84_in_valid = 1'b1;
        @(posedge clk); #1;
        d84_a = 8'h05; d84_b = 8'h07; d84_cin = 1'b1;
        @(posedge clk); #1;
        d84_in_valid = 1'b0;
        check("d84_valid0", d84_out_valid, 1);
        check("d84_res0", {d84_cout, d84_ovf, d84_sum}, {1'b1, 1'b1, 8'h7F});
        @(posedge clk); #1;
        check("d84_valid1", d84_out_valid, 1);
        check("d84_res1", {d84_cout, d84_ovf, d84_sum}, {1'b0, 1'b0, 8'hFE});
        @(posedge clk); #1;
        check("d84_idle_valid", d84_out_valid, 0);
        check("d84_idle_hold", d84_sum, 8'hFE);

        // 16/4: 20 back-to-back beats, sum = 4*i + i[0].
        first16 = -1; got16 = 0;
        for (int i = 0; i < 20; i++) begin
            send16(16'(i), 16'(3 * i), i[0], 1'b0, {2'b00, 16'(4 * i + (i & 1))});
            if (i == 0) lat = acc_cyc16;
        end
        drain16();
        check("d16_fill_latency", first16 - lat, 4);
        check("d16_full_rate", last16 - first16, 19);
        check("d16_count", got16, 20);

        // Backpressure with a full pipeline.
        fork
            begin
                for (int i = 0; i < 12; i++) begin
                    send16(16'h7000 + 16'(i * 16'h0123), 16'(i * 16'h1111), i[1], i[0],
                           model(16, 16'h7000 + 16'(i * 16'h0123), 16'(i * 16'h1111), i[1], i[0]));
                end
            end
            begin
                lat = 0;
                while (!d16_out_valid && lat < 50) begin
                    @(posedge clk); #1;
                    lat++;
                end
                check("d16_bp_fill", d16_out_valid, 1);
                d16_out_ready = 1'b0;
                held = {d16_cout, d16_ovf, d16_sum};
                repeat (5) begin
                    @(negedge clk);
                    check("d16_bp_in_ready", d16_in_ready, 0);
                    check("d16_bp_valid", d16_out_valid, 1);
                    check("d16_bp_hold", {14'd0, d16_cout, d16_ovf, d16_sum}, {14'd0, held});
                end
                @(posedge clk); #1;
                d16_out_ready = 1'b1;
            end
        join
        drain16();

        // Reset with three beats in flight.
        for (int i = 0; i < 3; i++) begin
            send16(16'h1234 + 16'(i), 16'h0101, 1'b0, 1'b0, model(16, 16'h1234 + 16'(i), 16'h0101, 1'b0, 1'b0));
        end
        rst16 = 1'b1;
        @(negedge clk);
        check("d16_rst_in_ready", d16_in_ready, 1);
        @(posedge clk); #1;
        rst16 = 1'b0;
        exp16_q.delete();
        check("d16_rst_valid", d16_out_valid, 0);
        check("d16_rst_sum", d16_sum, 0);
        check("d16_rst_cout", d16_cout, 0);
        check("d16_rst_ovf", d16_ovf, 0);
        got16 = 0;
        repeat (10) @(posedge clk);
        #1;
        check("d16_no_stale", got16, 0);
        send16(16'hFFFF, 16'h0000, 1'b1, 1'b0, {1'b1, 1'b0, 16'h0000});
        drain16();
        check("d16_post_rst_count", got16, 1);

        // Random regression on 12/2 with random gaps and backpressure.
        fork
            begin
                while (!rand_done) begin
                    @(posedge clk); #1;
                    d12_out_ready = ($urandom_range(0, 3) != 0);
                end
                d12_out_ready = 1'b1;
            end
            begin
                for (int i = 0; i < 10000; i++) begin
                    if ($urandom_range(0, 3) == 0) begin
                        @(posedge clk); #1;
                    end
                    send12(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)),
                           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
                end
                rand_done = 1'b1;
            end
        join
        for (int t = 0; t < 200 && exp12_q.size() != 0; t++) begin
            @(posedge clk); #1;
        end
        check("d12_drain", exp12_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
